uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial-to-parallel UART receiver: receive stage paired with uart_tx.
//  - Samples asynchronous serial line rx, NUM_WORDS frames per packet.
//  - Frame: 1 start bit, BITS_PER_WORD data bits LSB first, then (PACKET_SIZE-BITS_PER_WORD-1) stop/pad bits of 1.
//  - Word 0 is received first and lands in m_data[BITS_PER_WORD-1:0].
//  - Presents each assembled W_OUT-bit packet on a valid/ready master stream.
// PARAMETERS
//  CLOCKS_PER_PULSE  4    clk cycles per bit period (>=4, even)
//  BITS_PER_WORD     8    data bits per frame
//  PACKET_SIZE       13   bits per frame incl. start and stop/pad (>=BITS_PER_WORD+2)
//  W_OUT             16   packet width; multiple of BITS_PER_WORD; NUM_WORDS=W_OUT/BITS_PER_WORD
// PORTS
//  clk       in   1      single clock; all logic on posedge
//  rst       in   1      asynchronous, active-high reset
//  rx        in   1      serial line, idle high, asynchronous to clk
//  m_data    out  W_OUT  received packet, word iw at [iw*BITS_PER_WORD +: BITS_PER_WORD]
//  m_valid   out  1      m_data holds an unconsumed packet
//  m_ready   in   1      downstream accepts when m_valid && m_ready at posedge
// BEHAVIOUR
//  Reset: m_valid=0, m_data=0, state=IDLE, all counters 0, sync flops=1; applies immediately, any state.
//  rx passes a 2-flop synchronizer (rx_s); all decisions use rx_s.
//  FSM per frame:
//   IDLE : wait for falling edge of rx_s (prev 1, now 0); clear clk counter -> START.
//          A stuck-low line never retriggers.
//   START: after CLOCKS_PER_PULSE/2 cycles, sample rx_s.
//          0 -> clear clk counter, DATA. 1 -> glitch, IDLE (word counter unchanged).
//   DATA : every CLOCKS_PER_PULSE cycles sample rx_s into shift reg, LSB first.
//          After BITS_PER_WORD samples -> STOP.
//   STOP : every CLOCKS_PER_PULSE cycles sample one stop/pad bit; all must be 1.
//          Any 0 -> frame error: discard partial packet, word counter=0, IDLE.
//          All 1 -> store word at word counter index -> IDLE.
//          Last word: packet complete, word counter=0.
//  Sampling is mid-bit, so the line at a bit's last cycle is never used.
//  Packet completion (cycle after final stop sample):
//   - m_valid=0, or m_valid&&m_ready same cycle: m_data<=packet, m_valid<=1 next cycle.
//   - m_valid=1 && m_ready=0: overrun. New packet dropped; m_data/m_valid unchanged.
//  Handshake:
//   - m_valid falls the cycle after acceptance unless a new packet completes simultaneously.
//   - m_data stable while m_valid=1 && m_ready=0.
//  Packet assembled in internal staging reg; m_data touched only on completion.
//  Latency: m_valid rises 2 (sync) + 1 cycles after the middle of the last stop bit.
//  No inter-frame timeout: word index persists across idle gaps until packet end, frame error or reset.
//  Counters sized $clog2 of their maxima; no wrap beyond terminal counts.
// CONFIGURATION
//  UART_RX_STATUS_EN defined: adds outputs frame_err (1) and overrun (1), reset 0.
//   - Each pulses high exactly one cycle when its event occurs.
//   - Also adds err_count (8, saturating at 255) of both events combined.
//  Not defined: ports absent, events silently dropped; datapath behaviour identical.
// TESTING (CLOCKS_PER_PULSE=4, BITS_PER_WORD=8, PACKET_SIZE=13, W_OUT=16)
//  1 Loopback from uart_tx, s_data=16'hA55A, m_ready=1
//    -> one m_valid pulse, m_data=16'hA55A; repeat 10 random words, all match.
//  2 rx low 1 clk then high, idle 50 cycles
//    -> no state past START, m_valid stays 0, next packet 16'h1234 received correctly.
//  3 Word 0 sent with 2nd stop bit forced 0, then valid packet 16'hBEEF
//    -> first packet discarded (frame_err pulse if enabled), m_data=16'hBEEF.
//  4 m_ready=0, send 16'h0001 then 16'h0002
//    -> m_data stays 16'h0001 with m_valid=1, overrun pulse, err_count=1;
//       m_ready=1 -> accepted, m_valid=0.
//  5 rst pulse mid DATA of word 1
//    -> outputs return to reset values at once; next packet 16'hC3C3 received intact.
//  6 m_ready asserted exactly on completion cycle of back-to-back packets
//    -> both delivered in order, no overrun.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: serial-to-parallel UART receiver, paired with uart_tx.
// Each frame is 1 start bit, BITS_PER_WORD data bits (LSB first), then
// PACKET_SIZE-BITS_PER_WORD-1 stop/pad bits of 1. NUM_WORDS frames make one
// W_OUT-bit packet, which is presented on a valid/ready master stream.
// Word 0 arrives first and lands in m_data[BITS_PER_WORD-1:0].
// Optional macro UART_RX_STATUS_EN adds frame_err/overrun pulses and a
// saturating err_count of both events.
module uart_rx #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE      = 13,
  parameter int W_OUT            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [W_OUT-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
`ifdef UART_RX_STATUS_EN
  ,
  output logic             frame_err,
  output logic             overrun,
  output logic [7:0]       err_count
`endif
);

  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int NUM_STOP  = PACKET_SIZE - BITS_PER_WORD - 1;

  // Counter widths: $clog2 of the count range, at least one bit.
  localparam int CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int BW = (BITS_PER_WORD    > 1) ? $clog2(BITS_PER_WORD)    : 1;
  localparam int SW = (NUM_STOP         > 1) ? $clog2(NUM_STOP)         : 1;
  localparam int WW = (NUM_WORDS        > 1) ? $clog2(NUM_WORDS)        : 1;

  localparam logic [CW-1:0] CNT_FULL  = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_WORD - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(NUM_STOP - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                   state;
  logic                     rx_meta, rx_s, rx_prev;
  logic [CW-1:0]            clk_cnt;
  logic [BW-1:0]            bit_cnt;
  logic [SW-1:0]            stop_cnt;
  logic [WW-1:0]            word_cnt;
  logic [BITS_PER_WORD-1:0] shreg;
  logic [BITS_PER_WORD:0]   sh_cat;
  logic [W_OUT-1:0]         stage;
  logic                     pkt_done;

  // New bit enters at the MSB so that after a full word the first bit is at [0].
  assign sh_cat = {rx_s, shreg};

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Frame FSM: start detect, mid-bit sampling, stop check, word staging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      word_cnt <= '0;
      shreg    <= '0;
      stage    <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          // Only a 1->0 transition starts a frame; a stuck-low line is ignored.
          if (rx_prev && !rx_s) begin
            clk_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            // High at mid start bit means a glitch; word index is kept.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == CNT_FULL) begin
            clk_cnt <= '0;
            shreg   <= sh_cat[BITS_PER_WORD:1];
            if (bit_cnt == BIT_LAST) begin
              bit_cnt  <= '0;
              stop_cnt <= '0;
              state    <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == CNT_FULL) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              // Frame error: the whole partial packet is thrown away.
              stop_cnt <= '0;
              word_cnt <= '0;
              stage    <= '0;
              state    <= IDLE;
            end else if (stop_cnt == STOP_LAST) begin
              stop_cnt <= '0;
              state    <= IDLE;
              for (int i = 0; i < NUM_WORDS; i++) begin
                if (word_cnt == WW'(i))
                  stage[i*BITS_PER_WORD +: BITS_PER_WORD] <= shreg;
              end
              if (word_cnt == WORD_LAST) begin
                word_cnt <= '0;
                pkt_done <= 1'b1;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stream: load on completion if the slot is free or being drained,
  // otherwise drop the new packet and keep the held one stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (pkt_done && (!m_valid || m_ready)) begin
      m_valid <= 1'b1;
      m_data  <= stage;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef UART_RX_STATUS_EN
  logic       ferr_evt, ovr_evt;
  logic [1:0] n_evt;

  assign ferr_evt = (state == STOP) && (clk_cnt == CNT_FULL) && !rx_s;
  assign ovr_evt  = pkt_done && m_valid && !m_ready;
  assign n_evt    = {1'b0, ferr_evt} + {1'b0, ovr_evt};

  // Status: one-cycle event pulses and a saturating combined error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= ferr_evt;
      overrun   <= ovr_evt;
      if (({1'b0, err_count} + {7'd0, n_evt}) > 9'd255)
        err_count <= 8'hFF;
      else
        err_count <= err_count + {6'd0, n_evt};
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (CPP=4, 8-bit words, 13-bit
// frames, 16-bit packets). Table vectors, hand-written corner sequences and a
// randomized frame stream checked against a frame-level reference model.
module tb_uart_rx;
  localparam int CPP   = 4;
  localparam int BPW   = 8;
  localparam int PSZ   = 13;
  localparam int WOUT  = 16;
  localparam int NSTOP = PSZ - BPW - 1;
  localparam int NW    = WOUT / BPW;

  logic            clk, rst, rx, m_valid, m_ready;
  logic [WOUT-1:0] m_data;
`ifdef UART_RX_STATUS_EN
  logic            frame_err, overrun;
  logic [7:0]      err_count;
`endif

  uart_rx #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(BPW), .PACKET_SIZE(PSZ), .W_OUT(WOUT)) dut (
    .clk(clk), .rst(rst), .rx(rx), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef UART_RX_STATUS_EN
    , .frame_err(frame_err), .overrun(overrun), .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [WOUT-1:0] got[$];

  // Capture every accepted packet and count status pulses, away from posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) got.push_back(m_data);
`ifdef UART_RX_STATUS_EN
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // All drive tasks enter and leave 1 time unit after a posedge.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPP) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bad_stop >= 0 forces that stop bit low.
  task automatic send_frame(input logic [BPW-1:0] w, input int bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < BPW; i++) send_bit(w[i]);
    for (int j = 0; j < NSTOP; j++) send_bit(j == bad_stop ? 1'b0 : 1'b1);
  endtask

  task automatic send_packet(input logic [WOUT-1:0] p);
    for (int k = 0; k < NW; k++) send_frame(p[k*BPW +: BPW], -1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
  endtask

  typedef struct {
    logic [WOUT-1:0] data;
    bit              bad;    // send only word 0 with its 2nd stop bit low
    int              n_exp;
    logic [WOUT-1:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WOUT-1:0] acc, p1, p2;
    logic [BPW-1:0]  w;
    logic [WOUT-1:0] exp_q[$];
    int pw, nferr, k;

    vecs[0] = '{16'hA55A, 1'b0, 1, 16'hA55A};
    vecs[1] = '{16'h1234, 1'b0, 1, 16'h1234};
    vecs[2] = '{16'h00FF, 1'b1, 0, 16'h0000};
    vecs[3] = '{16'hBEEF, 1'b0, 1, 16'hBEEF};
    vecs[4] = '{16'h0000, 1'b0, 1, 16'h0000};
    vecs[5] = '{16'hFFFF, 1'b0, 1, 16'hFFFF};

    rst = 1'b1; rx = 1'b1; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    rst = 1'b0;
    idle(4);
    chk("post_rst_valid", m_valid, 0);

    // Table vectors with m_ready held high.
    m_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      got.delete();
      ferr_cnt = 0;
      if (vecs[v].bad) begin
        send_frame(vecs[v].data[BPW-1:0], 1);
        idle(CPP);
      end else begin
        send_packet(vecs[v].data);
      end
      idle(12);
      chk($sformatf("vec%0d_count", v), got.size(), vecs[v].n_exp);
      if (vecs[v].n_exp == 1 && got.size() > 0)
        chk($sformatf("vec%0d_data", v), got[0], vecs[v].exp_data);
`ifdef UART_RX_STATUS_EN
      chk($sformatf("vec%0d_ferr", v), ferr_cnt, vecs[v].bad ? 1 : 0);
`endif
    end

    // One-cycle low glitch must not start a frame.
    got.delete();
    rx = 1'b0;
    @(posedge clk);
    #1;
    idle(50);
    chk("glitch_count", got.size(), 0);
    chk("glitch_valid", m_valid, 0);
    send_packet(16'h1234);
    idle(12);
    chk("glitch_next_count", got.size(), 1);
    if (got.size() > 0) chk("glitch_next_data", got[0], 16'h1234);

    // Overrun: second packet dropped while the first is held.
    do_reset();
    m_ready = 1'b0;
    send_packet(16'h0001);
    send_packet(16'h0002);
    idle(12);
    chk("ovr_valid", m_valid, 1);
    chk("ovr_data", m_data, 16'h0001);
`ifdef UART_RX_STATUS_EN
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_err_count", err_count, 1);
`endif
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ovr_drain_valid", m_valid, 0);
    chk("ovr_drain_count", got.size(), 1);
    if (got.size() > 0) chk("ovr_drain_data", got[0], 16'h0001);
    @(posedge clk);
    #1;

    // Reset mid DATA of word 1 while a packet is held.
    m_ready = 1'b0;
    send_packet(16'h5A5A);
    send_frame(8'h77, -1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    chk("pre_rst_valid", m_valid, 1);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk("async_rst_valid", m_valid, 0);
    chk("async_rst_data", m_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got.delete();
    m_ready = 1'b1;
    idle(20);
    send_packet(16'hC3C3);
    idle(12);
    chk("after_rst_count", got.size(), 1);
    if (got.size() > 0) chk("after_rst_data", got[0], 16'hC3C3);

    // Back-to-back packets, m_ready high only on the 2nd completion edge.
    do_reset();
    m_ready = 1'b0;
    p1 = 16'h1357;
    p2 = 16'h2468;
    k = 0;
    fork
      begin
        send_packet(p1);
        send_packet(p2);
        idle(12);
      end
      begin
        while (!m_valid && k < 400) begin
          @(negedge clk);
          k++;
        end
        // Packets recur every 2*13*4 = 104 cycles on a continuous line.
        repeat (NW * PSZ * CPP - 1) @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
        @(negedge clk);
        chk("b2b_valid", m_valid, 1);
        chk("b2b_data", m_data, p2);
      end
    join
    chk("b2b_wait_ok", (k < 400), 1);
    m_ready = 1'b1;
    idle(4);
    chk("b2b_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("b2b_first", got[0], p1);
      chk("b2b_second", got[1], p2);
    end
    chk("b2b_final_valid", m_valid, 0);
`ifdef UART_RX_STATUS_EN
    chk("b2b_no_overrun", ovr_cnt, 0);
`endif

    // Random frame stream with injected stop-bit errors vs frame-level model.
    do_reset();
    m_ready = 1'b1;
    idle(4);
    pw = 0; nferr = 0; acc = '0;
    exp_q.delete();
    for (int f = 0; f < 40; f++) begin
      w = BPW'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        send_frame(w, int'($urandom_range(0, NSTOP - 1)));
        idle(CPP);
        pw = 0;
        nferr++;
      end else begin
        send_frame(w, -1);
        acc[pw*BPW +: BPW] = w;
        pw++;
        if (pw == NW) begin
          exp_q.push_back(acc);
          pw = 0;
        end
      end
      idle(int'($urandom_range(0, 6)));
    end
    idle(20);
    chk("rand_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("rand_pkt%0d", i), got[i], exp_q[i]);
`ifdef UART_RX_STATUS_EN
    chk("rand_ferr", ferr_cnt, nferr);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
